// File: rtl/beep_scheduler.sv
// Piezo beep arbiter: alarm > chime > click, each with its own on/off pattern,
// gated by a square-wave tone. Outputs are decoded purely from registers.
module beep_scheduler #(
    parameter int TONE_DIV         = 12500,
    parameter int ALARM_ON_MS      = 500,
    parameter int ALARM_OFF_MS     = 500,
    parameter int ALARM_TIMEOUT_MS = 60000,
    parameter int CHIME_ON_MS      = 200,
    parameter int CHIME_GAP_MS     = 300,
    parameter int CLICK_MS         = 30
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick_ms,
    input  logic       i_alarm_req,
    input  logic       i_alarm_off,
    input  logic       i_chime_req,
    input  logic [4:0] i_chime_hour,
    input  logic       i_chime_en,
    input  logic       i_click_req,
    output logic       o_beep,
    output logic       o_alarm_active,
    output logic       o_chime_active,
    output logic       o_busy
);

    localparam int MAX_A  = (ALARM_ON_MS > ALARM_OFF_MS) ? ALARM_ON_MS : ALARM_OFF_MS;
    localparam int MAX_B  = (ALARM_TIMEOUT_MS > MAX_A) ? ALARM_TIMEOUT_MS : MAX_A;
    localparam int MAX_C  = (CHIME_ON_MS > CHIME_GAP_MS) ? CHIME_ON_MS : CHIME_GAP_MS;
    localparam int MAX_D  = (CLICK_MS > MAX_C) ? CLICK_MS : MAX_C;
    localparam int MAX_MS = (MAX_B > MAX_D) ? MAX_B : MAX_D;
    localparam int CW     = $clog2(MAX_MS + 1);
    localparam int TW     = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [CW-1:0] AON_LAST   = CW'(ALARM_ON_MS - 1);
    localparam logic [CW-1:0] AOFF_LAST  = CW'(ALARM_OFF_MS - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(ALARM_TIMEOUT_MS - 1);
    localparam logic [CW-1:0] CON_LAST   = CW'(CHIME_ON_MS - 1);
    localparam logic [CW-1:0] CGAP_LAST  = CW'(CHIME_GAP_MS - 1);
    localparam logic [CW-1:0] CLICK_LAST = CW'(CLICK_MS - 1);
    localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALARM_ON,
        S_ALARM_OFF,
        S_CHIME_ON,
        S_CHIME_GAP,
        S_CLICK
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_ms_cnt;
    logic [CW-1:0]   w_ms_cnt_next;
    logic [CW-1:0]   r_to_cnt;
    logic [CW-1:0]   w_to_cnt_next;
    logic [3:0]      r_chime_left;
    logic [3:0]      w_chime_left_next;
    logic [TW-1:0]   r_tone_cnt;
    logic [TW-1:0]   w_tone_cnt_next;
    logic            r_tone_phase;
    logic            w_tone_phase_next;

    logic            w_alarm_active;
    logic            w_state_change;
    logic            w_next_on;
    logic            w_next_alarm;
    logic [4:0]      w_hour_mod;
    logic [3:0]      w_chime_beeps;

    assign w_alarm_active = (r_state == S_ALARM_ON) || (r_state == S_ALARM_OFF);
    assign w_hour_mod     = i_chime_hour % 5'd12;
    assign w_chime_beeps  = (w_hour_mod == 5'd0) ? 4'd12 : w_hour_mod[3:0];

    // Request arbitration first; only when no request is accepted does the
    // current sequence advance on the ms tick.
    always_comb begin
        w_state_next      = r_state;
        w_chime_left_next = r_chime_left;
        if (i_alarm_off && w_alarm_active) begin
            w_state_next = S_IDLE;
        end else if (i_alarm_req && !w_alarm_active) begin
            w_state_next = S_ALARM_ON;
        end else if (i_chime_req && i_chime_en &&
                     ((r_state == S_IDLE) || (r_state == S_CLICK))) begin
            w_state_next      = S_CHIME_ON;
            w_chime_left_next = w_chime_beeps;
        end else if (i_click_req && (r_state == S_IDLE)) begin
            w_state_next = S_CLICK;
        end else if (i_tick_ms) begin
            case (r_state)
                S_ALARM_ON: begin
                    if (r_to_cnt == TO_LAST)
                        w_state_next = S_IDLE;
                    else if (r_ms_cnt == AON_LAST)
                        w_state_next = S_ALARM_OFF;
                end
                S_ALARM_OFF: begin
                    if (r_to_cnt == TO_LAST)
                        w_state_next = S_IDLE;
                    else if (r_ms_cnt == AOFF_LAST)
                        w_state_next = S_ALARM_ON;
                end
                S_CHIME_ON: begin
                    if (r_ms_cnt == CON_LAST) begin
                        w_chime_left_next = r_chime_left - 4'd1;
                        w_state_next      = (r_chime_left == 4'd1) ? S_IDLE : S_CHIME_GAP;
                    end
                end
                S_CHIME_GAP: begin
                    if (r_ms_cnt == CGAP_LAST)
                        w_state_next = S_CHIME_ON;
                end
                S_CLICK: begin
                    if (r_ms_cnt == CLICK_LAST)
                        w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_state_change = (w_state_next != r_state);
    assign w_next_on      = (w_state_next == S_ALARM_ON) || (w_state_next == S_CHIME_ON) ||
                            (w_state_next == S_CLICK);
    assign w_next_alarm   = (w_state_next == S_ALARM_ON) || (w_state_next == S_ALARM_OFF);

    always_comb begin
        w_ms_cnt_next = r_ms_cnt;
        if (w_state_change || (w_state_next == S_IDLE))
            w_ms_cnt_next = '0;
        else if (i_tick_ms)
            w_ms_cnt_next = r_ms_cnt + 1'b1;
    end

    // The timeout runs across both alarm phases and restarts only on a fresh alarm.
    always_comb begin
        w_to_cnt_next = r_to_cnt;
        if (!w_next_alarm || !w_alarm_active)
            w_to_cnt_next = '0;
        else if (i_tick_ms)
            w_to_cnt_next = r_to_cnt + 1'b1;
    end

    always_comb begin
        w_tone_cnt_next   = r_tone_cnt;
        w_tone_phase_next = r_tone_phase;
        if (!w_next_on) begin
            w_tone_cnt_next   = '0;
            w_tone_phase_next = 1'b0;
        end else if (w_state_change) begin
            w_tone_cnt_next   = '0;
            w_tone_phase_next = 1'b1;
        end else if (r_tone_cnt == TONE_LAST) begin
            w_tone_cnt_next   = '0;
            w_tone_phase_next = ~r_tone_phase;
        end else begin
            w_tone_cnt_next = r_tone_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_ms_cnt     <= '0;
            r_to_cnt     <= '0;
            r_chime_left <= '0;
            r_tone_cnt   <= '0;
            r_tone_phase <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ms_cnt     <= w_ms_cnt_next;
            r_to_cnt     <= w_to_cnt_next;
            r_chime_left <= w_chime_left_next;
            r_tone_cnt   <= w_tone_cnt_next;
            r_tone_phase <= w_tone_phase_next;
        end
    end

    assign o_beep         = ((r_state == S_ALARM_ON) || (r_state == S_CHIME_ON) ||
                             (r_state == S_CLICK)) && r_tone_phase;
    assign o_alarm_active = w_alarm_active;
    assign o_chime_active = (r_state == S_CHIME_ON) || (r_state == S_CHIME_GAP);
    assign o_busy         = (r_state != S_IDLE);

endmodule

// File: doc/beep_scheduler.md
Name: beep_scheduler

Overview:
- Owns the single piezo `beep` output of DigitalClock and arbitrates it among three requesters: alarm match, hourly chime, and key-click feedback.
- Priority is fixed: alarm > chime > click.
- For each source it generates the on/off pattern, gated by a square-wave tone.
- Sits between the time/alarm compare logic and the top-level `beep` pin; it is driven by the 1 ms tick from the clock divider and the debounced `key_alarm_off` pulse.

Parameters:
- TONE_DIV, 12500, clk cycles per tone half-period (2 kHz at 50 MHz); minimum 1.
- ALARM_ON_MS, 500, alarm burst on-time in tick_ms pulses.
- ALARM_OFF_MS, 500, alarm burst off-time in tick_ms pulses.
- ALARM_TIMEOUT_MS, 60000, total alarm duration before self-cancel; counted from alarm start.
- CHIME_ON_MS, 200, on-time of each chime beep.
- CHIME_GAP_MS, 300, silence between chime beeps.
- CLICK_MS, 30, key-click duration.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick_ms  in  1  one-cycle pulse, once per ms.
- alarm_req  in  1  one-cycle pulse when time == alarm time.
- alarm_off  in  1  one-cycle debounced pulse from the alarm-off key.
- chime_req  in  1  one-cycle pulse at mm:ss == 00:00.
- chime_hour  in  5  hour at the chime instant (0-23).
- chime_en  in  1  level; chime_req is ignored when 0.
- click_req  in  1  one-cycle pulse on any accepted mode/inc key press.
- beep  out  1  buzzer drive.
- alarm_active  out  1  alarm sequence in progress.
- chime_active  out  1  chime sequence in progress.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, all counters 0, tone_phase=0. beep, alarm_active, chime_active and busy are all 0 immediately. Any sequence in progress is abandoned and is not resumed after reset.
- States: IDLE, ALARM_ON, ALARM_OFF, CHIME_ON, CHIME_GAP, CLICK.
- Output decode:
  - beep = (state in {ALARM_ON, CHIME_ON, CLICK}) & tone_phase.
  - alarm_active = state in {ALARM_ON, ALARM_OFF}.
  - chime_active = state in {CHIME_ON, CHIME_GAP}.
  - All outputs are decoded from registers only; none depend combinationally on inputs.
- Tone generation:
  - On every transition into an ON state, tone_cnt is cleared and tone_phase is set to 1. beep is therefore high in the first cycle of the state, which is the cycle after the request is sampled.
  - tone_phase toggles every TONE_DIV clk cycles while in an ON state.
- Phase timing:
  - ms_cnt clears on every state change and increments on tick_ms.
  - A phase of N ms ends on the clk edge at which the Nth tick_ms is sampled.
- Arbitration, evaluated every cycle, highest priority first:
  1. alarm_off=1 while alarm_active -> IDLE next cycle; this wins over a same-cycle alarm_req.
  2. alarm_req=1 and not alarm_active -> ALARM_ON from any state; a chime or click in progress is dropped, not resumed. The timeout counter (to_cnt) is cleared.
  3. chime_req=1 & chime_en in IDLE or CLICK -> CHIME_ON. The click is dropped. The beep count is latched as chime_hour mod 12, with 0 mapped to 12 (0->12, 13->1, 23->11, out-of-range 24..31 taken mod 12 identically).
  4. click_req in IDLE -> CLICK.
  - Requests not accepted under these rules are discarded, not queued. This includes chime_req during an alarm, click_req while busy, and alarm_req while alarm_active.
  - alarm_off when not alarm_active is ignored. A same-cycle alarm_off + alarm_req from IDLE starts the alarm.
- Alarm sequence:
  - ALARM_ON (ALARM_ON_MS) <-> ALARM_OFF (ALARM_OFF_MS), repeating.
  - to_cnt increments on tick_ms in both states. When it reaches ALARM_TIMEOUT_MS -> IDLE, regardless of the current phase.
- Chime sequence:
  - CHIME_ON (CHIME_ON_MS) -> decrement remaining.
  - If remaining becomes 0 -> IDLE (no trailing gap); else -> CHIME_GAP (CHIME_GAP_MS) -> CHIME_ON.
  - A chime_req arriving during a chime is ignored.
- CLICK: lasts CLICK_MS, then -> IDLE.
- Widths: ms_cnt and to_cnt are sized by $clog2 of the largest parameter + 1; the chime count register is 4 bits. No counter wraps in legal use.

Test Plan:
Bench parameters: TONE_DIV=2, ALARM_ON_MS=3, ALARM_OFF_MS=2, ALARM_TIMEOUT_MS=20, CHIME_ON_MS=2, CHIME_GAP_MS=2, CLICK_MS=1, tick_ms every 10 clk.
1. Reset: assert rst=0 mid-ALARM_ON with beep toggling -> beep, alarm_active and busy are 0 in the same cycle, with no edge needed. After release, state is IDLE.
2. Chime: chime_req with chime_hour=13, chime_en=1 -> exactly 1 burst of 2 ms, then IDLE. Repeat with hour=0 -> 12 bursts with 11 gaps; chime_active is high for 46 ms.
3. Alarm and cancel: alarm_req -> beep high the next cycle and toggling every 2 clk. ON/OFF phases last 3/2 ms. alarm_off at 7 ms -> IDLE next cycle and beep=0. A second alarm_off later has no effect.
4. Alarm timeout: alarm_req with no alarm_off -> alarm_active falls exactly on the 20th tick_ms after start.
5. Preemption: start a hour=5 chime; after the 2nd beep, pulse alarm_req -> ALARM_ON next cycle and the chime is not resumed after alarm_off. Same-cycle chime_req + alarm_req -> alarm only.
6. Click rules: click_req in IDLE -> 1 ms beep. click_req during a chime is ignored. chime_req during CLICK -> CHIME_ON next cycle. chime_req with chime_en=0 -> stays IDLE.
